// File: rtl/sdram_avalon_arbiter.sv
// sdram_avalon_arbiter
//   Shares one SDRAM controller Avalon-MM slave (sd_*) between two
//   requesters (m0, m1). Each single-beat transaction is granted round-robin.
//   A grant takes one cycle and acceptance at least one more.
//   An in-order tag FIFO remembers which master issued each accepted read, so
//   every sd_readdatavalid beat is steered back to its issuer.
// Ports
//   clk_clk, reset_reset        : clock, synchronous active-high reset
//   m{0,1}_address/read/write/writedata/byteenable : requester inputs
//   m{0,1}_waitrequest          : low only in that master's accept cycle
//   m{0,1}_readdata/readdatavalid : broadcast data, routed valid
//   sd_*                        : SDRAM controller master side
//   rd_pending                  : outstanding read count
module sdram_avalon_arbiter #(
  parameter int ADDR_W      = 28,
  parameter int DATA_W      = 32,
  parameter int MAX_PENDING = 8
) (
  input  logic                      clk_clk,
  input  logic                      reset_reset,
  input  logic [ADDR_W-1:0]         m0_address,
  input  logic                      m0_read,
  input  logic                      m0_write,
  input  logic [DATA_W-1:0]         m0_writedata,
  input  logic [DATA_W/8-1:0]       m0_byteenable,
  output logic                      m0_waitrequest,
  output logic [DATA_W-1:0]         m0_readdata,
  output logic                      m0_readdatavalid,
  input  logic [ADDR_W-1:0]         m1_address,
  input  logic                      m1_read,
  input  logic                      m1_write,
  input  logic [DATA_W-1:0]         m1_writedata,
  input  logic [DATA_W/8-1:0]       m1_byteenable,
  output logic                      m1_waitrequest,
  output logic [DATA_W-1:0]         m1_readdata,
  output logic                      m1_readdatavalid,
  output logic [ADDR_W-1:0]         sd_address,
  output logic                      sd_read,
  output logic                      sd_write,
  output logic [DATA_W-1:0]         sd_writedata,
  output logic [DATA_W/8-1:0]       sd_byteenable,
  output logic                      sd_burstcount,
  input  logic                      sd_waitrequest,
  input  logic [DATA_W-1:0]         sd_readdata,
  input  logic                      sd_readdatavalid,
  output logic [$clog2(MAX_PENDING):0] rd_pending
);
  localparam int PW   = $clog2(MAX_PENDING);
  localparam int CW   = PW + 1;
  localparam int BE_W = DATA_W / 8;

  typedef enum logic {IDLE, BUSY} state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              rd;
    logic              wr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } req_t;

  state_e                 state_q, state_d;
  logic                   owner_q, owner_d;
  logic                   last_q, last_d;
  logic [MAX_PENDING-1:0] tag_q;
  logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]          cnt_q;

  req_t req0, req1, sel;
  logic rd_ok, elig0, elig1, busy, accept, push, pop, head;

  assign req0 = '{addr: m0_address, rd: m0_read, wr: m0_write,
                  wdata: m0_writedata, be: m0_byteenable};
  assign req1 = '{addr: m1_address, rd: m1_read, wr: m1_write,
                  wdata: m1_writedata, be: m1_byteenable};
  assign sel  = owner_q ? req1 : req0;

  // read wins over write, so a master asserting both is treated as a read
  // and must wait for FIFO space like any other read
  assign rd_ok = cnt_q < CW'(MAX_PENDING);
  assign elig0 = m0_read ? rd_ok : m0_write;
  assign elig1 = m1_read ? rd_ok : m1_write;

  // outputs are gated with reset so the reset cycle itself is quiet
  assign busy   = (state_q == BUSY) && !reset_reset;
  assign accept = busy && !sd_waitrequest && (sel.rd || sel.wr);
  assign push   = accept && sel.rd;
  assign pop    = !reset_reset && sd_readdatavalid && (cnt_q != '0);
  assign head   = tag_q[rd_ptr_q];

  assign sd_address    = sel.addr;
  assign sd_writedata  = sel.wdata;
  assign sd_byteenable = sel.be;
  assign sd_read       = busy && sel.rd;
  assign sd_write      = busy && !sel.rd && sel.wr;
  assign sd_burstcount = 1'b1;

  assign m0_waitrequest   = !(accept && !owner_q);
  assign m1_waitrequest   = !(accept &&  owner_q);
  assign m0_readdata      = sd_readdata;
  assign m1_readdata      = sd_readdata;
  assign m0_readdatavalid = pop && !head;
  assign m1_readdatavalid = pop &&  head;
  assign rd_pending       = cnt_q;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      IDLE: if (elig0 || elig1) begin
        state_d = BUSY;
        owner_d = (elig0 && elig1) ? !last_q : elig1;
      end
      BUSY: begin
        if (accept) begin
          last_d  = owner_q;
          state_d = IDLE;
        end else if (!(sel.rd || sel.wr)) begin
          // owner abandoned its request: release without touching last
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      if (push) tag_q[wr_ptr_q] <= owner_q;
      wr_ptr_q <= wr_ptr_q + PW'(push);
      rd_ptr_q <= rd_ptr_q + PW'(pop);
      cnt_q    <= cnt_q + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_sdram_avalon_arbiter.sv
// Randomized bench for sdram_avalon_arbiter. A transaction-level reference
// (grant flag, owner, round-robin pointer, queue of read issuers) predicts
// every output each cycle. Masters follow Avalon hold-until-accept rules,
// with rare request drops, random backpressure, random stray beats,
// starvation phases that fill the tag FIFO, and random mid-run resets.
module tb_sdram_avalon_arbiter;
  localparam int AW = 28, DW = 32, MP = 8, BW = DW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [1:0]    mrd, mwr;
  logic [AW-1:0] madr [2];
  logic [DW-1:0] mwd  [2];
  logic [BW-1:0] mbe  [2];
  logic [1:0]    mwait, mrdv;
  logic [DW-1:0] mrdata [2];
  logic [AW-1:0] sd_address;
  logic          sd_read, sd_write, sd_burstcount;
  logic [DW-1:0] sd_writedata;
  logic [BW-1:0] sd_byteenable;
  logic          sd_waitrequest, sd_readdatavalid;
  logic [DW-1:0] sd_readdata;
  logic [3:0]    rd_pending;

  sdram_avalon_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_PENDING(MP)) dut (
    .clk_clk(clk), .reset_reset(rst),
    .m0_address(madr[0]), .m0_read(mrd[0]), .m0_write(mwr[0]),
    .m0_writedata(mwd[0]), .m0_byteenable(mbe[0]),
    .m0_waitrequest(mwait[0]), .m0_readdata(mrdata[0]), .m0_readdatavalid(mrdv[0]),
    .m1_address(madr[1]), .m1_read(mrd[1]), .m1_write(mwr[1]),
    .m1_writedata(mwd[1]), .m1_byteenable(mbe[1]),
    .m1_waitrequest(mwait[1]), .m1_readdata(mrdata[1]), .m1_readdatavalid(mrdv[1]),
    .sd_address(sd_address), .sd_read(sd_read), .sd_write(sd_write),
    .sd_writedata(sd_writedata), .sd_byteenable(sd_byteenable),
    .sd_burstcount(sd_burstcount), .sd_waitrequest(sd_waitrequest),
    .sd_readdata(sd_readdata), .sd_readdatavalid(sd_readdatavalid),
    .rd_pending(rd_pending));

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference state
  bit granted;
  int own, last_won;
  int issuers[$];
  bit acc_prev [2];
  bit active [2];
  int n_grant_full = 0;

  initial begin
    bit e [2];
    bit xrd, xwr, xacc, xpop;
    int xtag, rdv_pct;
    rst = 1'b1; mrd = '0; mwr = '0; sd_waitrequest = 1'b0;
    sd_readdatavalid = 1'b0; sd_readdata = '0;
    for (int i = 0; i < 2; i++) begin
      madr[i] = '0; mwd[i] = '0; mbe[i] = '0; active[i] = 0; acc_prev[i] = 0;
    end
    granted = 0; own = 0; last_won = 1;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      rst = (cyc < 2) || ($urandom_range(0, 299) == 0);
      for (int i = 0; i < 2; i++) begin
        if (acc_prev[i]) active[i] = 0;
        if (active[i] && $urandom_range(0, 99) == 0) active[i] = 0;
        if (!active[i] && $urandom_range(0, 99) < 60) begin
          active[i] = 1;
          case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: begin mrd[i] = 1'b1; mwr[i] = 1'b0; end
            6, 7, 8:          begin mrd[i] = 1'b0; mwr[i] = 1'b1; end
            default:          begin mrd[i] = 1'b1; mwr[i] = 1'b1; end
          endcase
          madr[i] = AW'($urandom); mwd[i] = $urandom; mbe[i] = BW'($urandom);
        end
        if (!active[i]) begin mrd[i] = 1'b0; mwr[i] = 1'b0; end
      end
      // alternate between draining phases and starvation phases
      rdv_pct = ((cyc / 250) % 2 == 1) ? 0 : 45;
      sd_waitrequest   = $urandom_range(0, 99) < 30;
      sd_readdatavalid = $urandom_range(0, 99) < rdv_pct;
      sd_readdata      = $urandom;

      #1;
      xrd = 0; xwr = 0; xacc = 0; xpop = 0; xtag = 0;
      if (!rst) begin
        if (granted) begin
          xrd  = mrd[own];
          xwr  = !mrd[own] && mwr[own];
          xacc = !sd_waitrequest && (xrd || xwr);
        end
        if (sd_readdatavalid && issuers.size() > 0) begin
          xpop = 1; xtag = issuers[0];
        end
      end
      chk("sd_read", sd_read, xrd);
      chk("sd_write", sd_write, xwr);
      chk("burstcount", sd_burstcount, 1);
      chk("rd_pending", rd_pending, issuers.size());
      if (xrd || xwr) begin
        chk("sd_address", sd_address, madr[own]);
        if (xwr) begin
          chk("sd_writedata", sd_writedata, mwd[own]);
          chk("sd_byteenable", sd_byteenable, mbe[own]);
        end
      end
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("m%0d_waitrequest", i), mwait[i], !(xacc && own == i));
        chk($sformatf("m%0d_readdatavalid", i), mrdv[i], xpop && xtag == i);
        chk($sformatf("m%0d_readdata", i), mrdata[i], sd_readdata);
        acc_prev[i] = xacc && own == i;
      end

      // advance reference
      if (rst) begin
        granted = 0; own = 0; last_won = 1; issuers.delete();
      end else begin
        for (int i = 0; i < 2; i++)
          e[i] = mrd[i] ? (issuers.size() < MP) : mwr[i];
        if (xpop) void'(issuers.pop_front());
        if (granted) begin
          if (xacc) begin
            last_won = own;
            if (xrd) issuers.push_back(own);
            granted = 0;
          end else if (!(xrd || xwr)) granted = 0;
        end else if (e[0] || e[1]) begin
          granted = 1;
          own = (e[0] && e[1]) ? 1 - last_won : (e[1] ? 1 : 0);
          if (issuers.size() == MP) n_grant_full++;
        end
      end
    end

    // directed tail: fill the FIFO from m0, then a stray-free drain check
    @(negedge clk);
    rst = 1'b1; mrd = '0; mwr = '0; sd_readdatavalid = 1'b0; sd_waitrequest = 1'b0;
    @(negedge clk);
    rst = 1'b0; mrd[0] = 1'b1; madr[0] = AW'(28'h100);
    for (int k = 0; k < 24; k++) @(negedge clk);
    #1 chk("full_pending", rd_pending, MP);
    chk("full_stall", mwait[0], 1);
    chk("full_no_read", sd_read, 0);
    mrd[0] = 1'b0;
    sd_readdatavalid = 1'b1; sd_readdata = 32'hA;
    #1 chk("full_pop_rdv0", mrdv[0], 1);
    chk("full_pop_rdv1", mrdv[1], 0);
    @(negedge clk);
    sd_readdatavalid = 1'b0;
    #1 chk("full_after_pop", rd_pending, MP - 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; sd_readdatavalid = 1'b1;
    #1 chk("stray_rdv0", mrdv[0], 0);
    chk("stray_rdv1", mrdv[1], 0);
    chk("reset_pending", rd_pending, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
